// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu -- load/store unit, initiator side of the data-memory interface.
//
// Takes one load or store at a time from execute, rejects illegal width codes
// and misaligned addresses before anything reaches memory, drives a single
// cycle operation into the memory access unit, captures the registered result
// one cycle later, extends load data and returns a result or fault.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_store             1 = store, 0 = load
//   req_funct3            RISC-V width code (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr, req_wdata   byte address, store data
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             extended load data (0 for stores and faults)
//   rsp_fault, rsp_cause  fault flag and cause (01 misaligned, 10 illegal,
//                         11 memory fault)
//   mem_op                {store, size}; 000 outside the access cycle
//   mem_addr, mem_in      memory address (latched), write data
//   mem_out, mem_fault    registered memory read data / fault
// -----------------------------------------------------------------------------
module lsu (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault,
   output logic [1:0]  rsp_cause,
   output logic [2:0]  mem_op,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_in,
   input  logic [31:0] mem_out,
   input  logic        mem_fault
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_ACCESS = 2'b01,
      S_WAIT   = 2'b10,
      S_RESP   = 2'b11
   } state_t;

   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
   localparam logic [1:0] CAUSE_MEMFAULT = 2'b11;

   state_t      state_q;
   state_t      state_d;

   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        store_q;
   logic [2:0]  funct3_q;

   logic [31:0] rdata_q;
   logic        fault_q;
   logic [1:0]  cause_q;

   logic        req_legal;
   logic        req_misaligned;

   // Legal width codes: loads LB/LH/LW/LBU/LHU, stores SB/SH/SW only.
   function automatic logic funct3_legal(input logic store, input logic [2:0] f3);
      logic ok;
      if (store) begin
         ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
      end else begin
         ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
              (f3 == 3'b100) || (f3 == 3'b101);
      end
      return ok;
   endfunction

   // funct3[1:0] is the access size for every legal code.
   function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lsb);
      logic mis;
      case (f3[1:0])
         2'b01:   mis = lsb[0];
         2'b10:   mis = (lsb != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

   // Memory returns zero-extended data; signed loads widen it here.
   function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] data);
      logic signed [7:0]  byte_s;
      logic signed [15:0] half_s;
      logic signed [31:0] ext_s;
      byte_s = data[7:0];
      half_s = data[15:0];
      case (f3)
         3'b000:  ext_s = 32'(byte_s);
         3'b001:  ext_s = 32'(half_s);
         3'b100:  ext_s = signed'({24'd0, data[7:0]});
         3'b101:  ext_s = signed'({16'd0, data[15:0]});
         default: ext_s = data;
      endcase
      return ext_s;
   endfunction

   assign req_legal      = funct3_legal(req_store, req_funct3);
   assign req_misaligned = addr_misaligned(req_funct3, req_addr[1:0]);

   // State register: reset forces IDLE at once, which also drops mem_op
   // asynchronously if reset lands in the middle of an access.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      mem_op    = 3'b000;
      mem_in    = 32'd0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               // Rejected requests skip memory entirely: memory would
               // commit a misaligned store without complaint.
               if (!req_legal || req_misaligned) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_ACCESS;
               end
            end
         end
         S_ACCESS: begin
            mem_op  = {store_q, funct3_q[1:0]};
            mem_in  = wdata_q;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            state_d = S_RESP;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Request latch and response registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         store_q  <= 1'b0;
         funct3_q <= 3'b000;
         rdata_q  <= 32'd0;
         fault_q  <= 1'b0;
         cause_q  <= CAUSE_NONE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  addr_q   <= req_addr;
                  wdata_q  <= req_wdata;
                  store_q  <= req_store;
                  funct3_q <= req_funct3;
                  if (!req_legal) begin
                     rdata_q <= 32'd0;
                     fault_q <= 1'b1;
                     cause_q <= CAUSE_ILLEGAL;
                  end else if (req_misaligned) begin
                     rdata_q <= 32'd0;
                     fault_q <= 1'b1;
                     cause_q <= CAUSE_MISALIGN;
                  end
               end
            end
            S_WAIT: begin
               // mem_out/mem_fault here are the memory's registered
               // answer to the ACCESS cycle.
               if (mem_fault) begin
                  rdata_q <= 32'd0;
                  fault_q <= 1'b1;
                  cause_q <= CAUSE_MEMFAULT;
               end else if (store_q) begin
                  rdata_q <= 32'd0;
                  fault_q <= 1'b0;
                  cause_q <= CAUSE_NONE;
               end else begin
                  rdata_q <= extend_load(funct3_q, mem_out);
                  fault_q <= 1'b0;
                  cause_q <= CAUSE_NONE;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rdata_q <= 32'd0;
                  fault_q <= 1'b0;
                  cause_q <= CAUSE_NONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign rsp_rdata = rdata_q;
   assign rsp_fault = fault_q;
   assign rsp_cause = cause_q;
   assign mem_addr  = addr_q;

endmodule
